// File: rtl/vlsi_enc_pkg.sv
// Shared definitions for the sequential round-robin 4-to-2 encoder.
//   N          number of request lines
//   W          index width, clog2(N)
//   ostate_t   output register state: EMPTY (valid=0) / FULL (valid=1)
//   enc_dbg_t  debug view of the encoder state (output state + rr pointer)
//   onehot()   index -> one-hot mask helper
package vlsi_enc_pkg;

  localparam int N = 4;
  localparam int W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  typedef struct packed {
    ostate_t        state;
    logic [W-1:0]   ptr;
  } enc_dbg_t;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/vlsi_seq_encoder_rr_pick.sv
// Combinational circular first-one finder.
//   pending  in  N  request vector to search
//   ptr      in  W  index where the search starts
//   g        out W  first set index at or after ptr (wrapping); 0 if none
//   any      out 1  pending has at least one bit set
module rr_pick
  import vlsi_enc_pkg::*;
(
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] g,
  output logic         any
);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    g     = '0;
    idx   = '0;
    found = 1'b0;
    // idx wraps naturally because N is a power of two.
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!found && pending[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    any = |pending;
  end

endmodule

// File: rtl/vlsi_seq_encoder.sv
// Sequential round-robin 4-to-2 encoder. Request lines are accumulated in a
// pending register and emitted one index at a time through a registered
// valid/ready output stage.
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   enable   in   1  sample `in` at each edge when high
//   in       in   N  level-sampled request lines
//   ready    in   1  downstream accepts `out`
//   out      out  W  granted index
//   valid    out  1  `out` holds an unaccepted index
//   pending  out  N  queued requests not yet encoded
//   drop     out  1  one-cycle pulse: a request merged into a pending bit
//   dbg      out     output-state and round-robin pointer, for observation
//
// Handshake: a transfer happens at a rising edge where valid && ready. Once
// valid is high, out is stable until that edge; valid never drops without a
// transfer. All outputs are registered; ready and in reach no output
// combinationally.
module vlsi_seq_encoder
  import vlsi_enc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [N-1:0]   in,
  input  logic           ready,
  output logic [W-1:0]   out,
  output logic           valid,
  output logic [N-1:0]   pending,
  output logic           drop,
  output enc_dbg_t       dbg
);

  ostate_t        state;
  logic [W-1:0]   ptr;
  logic [W-1:0]   g;
  logic           any;
  logic           load;
  logic [N-1:0]   gmask;
  logic [N-1:0]   req;

  rr_pick u_pick (
    .pending (pending),
    .ptr     (ptr),
    .g       (g),
    .any     (any)
  );

  // The output register may take a new index when it is empty or its
  // current index is being accepted this edge.
  assign load  = ((state == EMPTY) || ready) && any;
  assign gmask = load ? onehot(g) : '0;
  assign req   = enable ? in : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      out     <= '0;
      ptr     <= '0;
      pending <= '0;
      drop    <= 1'b0;
    end else begin
      // New requests are OR-ed in after the grant clear, so a bit granted
      // and re-requested on the same edge stays pending.
      pending <= (pending & ~gmask) | req;
      // Only a request landing on a bit that stays pending is lost.
      drop    <= |(req & pending & ~gmask);

      if (load) begin
        state <= FULL;
        out   <= g;
        ptr   <= g + W'(1);
      end else if (state == FULL && ready) begin
        state <= EMPTY;
      end
    end
  end

  assign valid     = (state == FULL);
  assign dbg.state = state;
  assign dbg.ptr   = ptr;

endmodule

// File: tb/tb_vlsi_seq_encoder.sv
module tb_vlsi_seq_encoder;
  import vlsi_enc_pkg::*;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [3:0]     din = '0;
  logic           ready = 1'b0;
  logic [1:0]     out;
  logic           valid;
  logic [3:0]     pending;
  logic           drop;
  enc_dbg_t       dbg;

  always #5 clk = ~clk;

  vlsi_seq_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .in      (din),
    .ready   (ready),
    .out     (out),
    .valid   (valid),
    .pending (pending),
    .drop    (drop),
    .dbg     (dbg)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: a set of queued request numbers, a start position for
  // the circular search, and the currently offered index.
  bit  m_pend[4];
  int  m_ptr;
  int  m_out;
  bit  m_valid;
  bit  m_drop;

  function automatic int pend_val();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_ptr = 0; m_out = 0; m_valid = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] inp, input bit rdy);
    int  granted;
    bit  can_take;
    bit  nxt[4];
    granted  = -1;
    can_take = (!m_valid || rdy) && (pend_val() != 0);
    if (can_take) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (granted < 0 && m_pend[idx]) granted = idx;
      end
    end
    for (int i = 0; i < 4; i++) nxt[i] = m_pend[i] && (i != granted);
    m_drop = 0;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (inp[i]) begin
          if (m_pend[i] && i != granted) m_drop = 1;
          nxt[i] = 1;
        end
      end
    end
    for (int i = 0; i < 4; i++) m_pend[i] = nxt[i];
    if (can_take) begin
      m_out = granted; m_valid = 1; m_ptr = (granted + 1) % 4;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"},     int'(out),     m_out);
    chk({tag, ".valid"},   int'(valid),   int'(m_valid));
    chk({tag, ".pending"}, int'(pending), pend_val());
    chk({tag, ".drop"},    int'(drop),    int'(m_drop));
    chk({tag, ".ptr"},     int'(dbg.ptr), m_ptr);
    chk({tag, ".state"},   int'(dbg.state), int'(m_valid));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change away from the rising edge; outputs are sampled #1 after it.
  task automatic step(input bit en, input logic [3:0] inp, input bit rdy);
    enable = en; din = inp; ready = rdy;
    @(posedge clk);
    model_step(en, inp, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  inp;
    bit          rdy;
    logic [1:0]  e_out;
    bit          e_valid;
    logic [3:0]  e_pend;
    bit          e_drop;
    logic [1:0]  e_ptr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // rst en  in       rdy out val pend    drop ptr
    // single request
    tbl.push_back('{1, 1, 4'b0100, 1, 0, 0, 4'b0100, 0, 0});
    tbl.push_back('{0, 0, 4'b0000, 1, 2, 1, 4'b0000, 0, 3});
    tbl.push_back('{0, 0, 4'b0000, 1, 2, 0, 4'b0000, 0, 3});
    // round-robin from reset
    tbl.push_back('{1, 1, 4'b1111, 1, 0, 0, 4'b1111, 0, 0});
    tbl.push_back('{0, 0, 4'b0000, 1, 0, 1, 4'b1110, 0, 1});
    tbl.push_back('{0, 0, 4'b0000, 1, 1, 1, 4'b1100, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 1, 2, 1, 4'b1000, 0, 3});
    tbl.push_back('{0, 0, 4'b0000, 1, 3, 1, 4'b0000, 0, 0});
    tbl.push_back('{0, 1, 4'b1001, 1, 3, 0, 4'b1001, 0, 0});
    tbl.push_back('{0, 0, 4'b0000, 1, 0, 1, 4'b1000, 0, 1});
    tbl.push_back('{0, 0, 4'b0000, 1, 3, 1, 4'b0000, 0, 0});
    tbl.push_back('{0, 0, 4'b0000, 1, 3, 0, 4'b0000, 0, 0});
    // backpressure: hold out=1 for three stalled cycles
    tbl.push_back('{0, 1, 4'b0010, 0, 3, 0, 4'b0010, 0, 0});
    tbl.push_back('{0, 1, 4'b1000, 0, 1, 1, 4'b1000, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 0, 1, 1, 4'b1000, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 0, 1, 1, 4'b1000, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 0, 1, 1, 4'b1000, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 1, 3, 1, 4'b0000, 0, 0});
    tbl.push_back('{0, 0, 4'b0000, 1, 3, 0, 4'b0000, 0, 0});
    // collision: re-request of a still-pending bit drops, with enable=0 it doesn't
    tbl.push_back('{0, 1, 4'b0011, 0, 3, 0, 4'b0011, 0, 0});
    tbl.push_back('{0, 1, 4'b0010, 0, 0, 1, 4'b0010, 1, 1});
    tbl.push_back('{0, 0, 4'b0000, 0, 0, 1, 4'b0010, 0, 1});
    tbl.push_back('{0, 0, 4'b0010, 0, 0, 1, 4'b0010, 0, 1});
    // set-over-clear: granted bit re-requested stays pending, no drop
    tbl.push_back('{0, 1, 4'b0010, 1, 1, 1, 4'b0010, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 1, 1, 1, 4'b0000, 0, 2});
    tbl.push_back('{0, 0, 4'b0000, 1, 1, 0, 4'b0000, 0, 2});
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();

    // Reset held with active requests: every output stays at its reset value.
    rst_n = 1'b0; enable = 1'b1; din = 4'b1111; ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst.out", int'(out), 0);
      chk("rst.valid", int'(valid), 0);
      chk("rst.pending", int'(pending), 0);
      chk("rst.drop", int'(drop), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b0000, 1'b1);
      check_model("idle");
    end

    // Directed table.
    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (tbl[i].rst) do_reset();
      step(tbl[i].en, tbl[i].inp, tbl[i].rdy);
      chk({t, ".out"},     int'(out),     int'(tbl[i].e_out));
      chk({t, ".valid"},   int'(valid),   int'(tbl[i].e_valid));
      chk({t, ".pending"}, int'(pending), int'(tbl[i].e_pend));
      chk({t, ".drop"},    int'(drop),    int'(tbl[i].e_drop));
      chk({t, ".ptr"},     int'(dbg.ptr), int'(tbl[i].e_ptr));
    end

    // Asynchronous reset mid-transfer: outputs clear without a clock edge.
    do_reset();
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", int'(valid), 0);
    chk("arst.pending", int'(pending), 0);
    chk("arst.out", int'(out), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized stimulus against the reference model.
    for (int c = 0; c < 600; c++) begin
      bit          en;
      logic [3:0]  inp;
      bit          rdy;
      if ($urandom_range(0, 79) == 0) do_reset();
      en  = ($urandom_range(0, 3) != 0);
      inp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rdy = ($urandom_range(0, 3) != 0);
      step(en, inp, rdy);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vlsi_seq_encoder.md
# vlsi_seq_encoder

Sequential round-robin 4-to-2 encoder: the reverse of the team's 2-to-4 enabled decoder. It collects request bits on `in`, queues them in a pending register and emits one 2-bit index at a time on `out` through a valid/ready handshake. It sits where decoded one-hot event lines must be turned back into a compact index for a downstream consumer that may stall.

## Interface
- `N`, 4: number of request lines; fixed at 4 in this revision.
- `W`, 2: index width, equal to clog2(`N`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when 1, `in` is sampled at each edge; when 0, `in` is ignored.
- `in`  in  N  request lines, level-sampled; multiple bits may be set.
- `ready`  in  1  downstream accepts `out` when `valid && ready` at an edge.
- `out`  out  W  encoded index of the granted request.
- `valid`  out  1  `out` holds an unaccepted index.
- `pending`  out  N  queued requests not yet encoded.
- `drop`  out  1  one-cycle pulse: a request merged into an already-pending bit.

## Operation
- Reset (asynchronous, `rst_n` = 0): `pending` = 0, `out` = 0, `valid` = 0, `drop` = 0, round-robin pointer `ptr` = 0. All outputs hold these values while `rst_n` is low. Reset mid-transfer discards all queued and held requests.
- Output register states: EMPTY (`valid` = 0) and FULL (`valid` = 1).
- Load condition: `load` = (EMPTY or `ready`) and `pending` != 0.
- Grant: search `pending` circularly starting at index `ptr`. The first set bit is the winner `g`.
- On `load`: `out` <= `g`, `valid` <= 1, `ptr` <= (`g` + 1) mod N, and bit `g` is cleared from `pending`.
- In FULL with `ready` = 1 and `pending` = 0: `valid` <= 0 (return to EMPTY). `out` keeps its last value.
- In FULL with `ready` = 0: `out`, `valid` and `ptr` hold.
- Pending update: `pending` <= (`pending` & ~grant_mask) | (`enable` ? `in` : 0). A set for a bit wins over a clear of the same bit, so a bit granted in the same cycle it is re-requested stays pending.
- `drop` <= `enable` && |(`in` & `pending` & ~grant_mask). The merged request is lost; only one occurrence is kept.
- `enable` = 0 does not stop draining: queued requests keep being encoded.

## Timing
- Latency: a request sampled at edge E0 appears in `pending` after E0. If the output register can load, `out`/`valid` update at E1, so the minimum latency is 1 cycle from `pending` to `valid`.
- Throughput: one index per cycle while `ready` = 1 and `pending` != 0. `valid` stays high across back-to-back transfers.
- `drop` is registered and asserts the cycle after the colliding sample edge, for one cycle per collision edge.
- No combinational path from `ready` or `in` to any output.

## Structure
- Shared package `vlsi_enc_pkg` holds `N`, `W`, and the output-state encoding (EMPTY = 0, FULL = 1).
- Sub-module `rr_pick`: purely combinational circular first-one finder. Inputs are `pending` and `ptr`; outputs are `g` and `any`. The top level holds all registers.
- Top-level RTL target: roughly 150 lines.

## Test plan
- Reset: `rst_n` = 0 with `in` = 4'b1111, `enable` = 1 → `out` = 0, `valid` = 0, `pending` = 0, `drop` = 0 for the whole reset. Deassert, then hold `in` = 0 → outputs stay at reset values.
- Single request: `in` = 4'b0100 for one cycle, `ready` = 1 → `pending` = 4'b0100, then `out` = 2, `valid` = 1 for exactly one cycle, then `valid` = 0 and `ptr` = 3.
- Round-robin: from reset, `in` = 4'b1111 for one cycle, `ready` = 1 → `out` sequence 0, 1, 2, 3 on consecutive cycles. Then `in` = 4'b1001 → `out` 0 then 3 (pointer wrapped to 0).
- Backpressure: `valid` = 1, `out` = 1, `ready` = 0 for 3 cycles while `in` = 4'b1000 → `out` holds 1 and `pending` = 4'b1000. Raise `ready` → `out` = 3 next cycle.
- Collision/drop: `pending` = 4'b0010, `ready` = 0, `in` = 4'b0010 → `drop` pulses once and `pending` stays 4'b0010. Repeat with `enable` = 0 → no pulse.
- Set-over-clear: `ptr` = 1, `pending` = 4'b0010, `ready` = 1, `in` = 4'b0010 → `out` = 1, `pending` remains 4'b0010, `drop` = 0, and the next `out` = 1 again.
